// File: rtl/axi_mac_src_pkg.sv
// Shared types and default operand geometry for the MAC operand stream.
// Package name is mac_stream_pkg; imported by the stream interface and the top.
package mac_stream_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int INT_A  = 6;
  localparam int FRAC_A = 8;
  localparam int INT_B  = 6;
  localparam int FRAC_B = 8;
  localparam int A_W    = INT_A + FRAC_A;
  localparam int B_W    = INT_B + FRAC_B;
  localparam int PAIR_W = A_W + B_W;
endpackage

// File: rtl/axi_mac_src_if.sv
// Operand stream toward the MAC accumulator: a/b pair with valid/ready/last handshake.
interface axi_mac_src_if #(
  parameter int A_W = mac_stream_pkg::A_W,
  parameter int B_W = mac_stream_pkg::B_W
) ();
  logic signed [A_W-1:0] a;
  logic signed [B_W-1:0] b;
  logic                  valid_o;
  logic                  last_o;
  logic                  ready_i;

  modport master (output a, b, valid_o, last_o, input ready_i);
  modport slave  (input a, b, valid_o, last_o, output ready_i);
endinterface

// File: rtl/axi_mac_src_pair_fifo.sv
// Synchronous operand-pair FIFO (module mac_pair_fifo); pointers carry an extra MSB
// so full and empty are distinguished without a separate counter.
module mac_pair_fifo #(
  parameter int PAIR_W = 28,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [PAIR_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [PAIR_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PAIR_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_level = r_wptr - r_rptr;
  // A push seen while full is lost even if a pop frees a slot on the same edge.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/axi_mac_src.sv
// Transmit side of the MAC operand stream: FIFO-buffered (a,b) pairs sent as vectors of vec_len beats.
// Optional macro AXI_MAC_SRC_OVF_EN adds a sticky ovf flag for writes dropped while full.
module axi_mac_src
  import mac_stream_pkg::*;
#(
  parameter int int_a  = 6,
  parameter int frac_a = 8,
  parameter int int_b  = 6,
  parameter int frac_b = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 8
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic signed [int_a+frac_a-1:0]   wr_a,
  input  logic signed [int_b+frac_b-1:0]   wr_b,
  output logic                             full,
  output logic [$clog2(DEPTH):0]           level,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 vec_len,
  output logic                             busy,
  output logic                             done,
  axi_mac_src_if.master                    m
`ifdef AXI_MAC_SRC_OVF_EN
  ,
  output logic                             ovf
`endif
);
  localparam int AW = int_a + frac_a;
  localparam int BW = int_b + frac_b;
  localparam int PW = AW + BW;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic signed [AW-1:0]  r_a_p1;
  logic signed [BW-1:0]  r_b_p1;
  logic                  r_vld_p1;
  logic                  r_last_p1;
  logic                  r_done;
  logic [PW-1:0]         w_head;
  logic                  w_empty;
  logic                  w_xfer;
  logic                  w_load;

  assign w_xfer = r_vld_p1 && m.ready_i;
  // Refill the output register only when it is free this cycle and the vector still owes beats.
  assign w_load = (r_state == RUN) && (!r_vld_p1 || w_xfer) && !w_empty && (r_cnt < r_len);

  mac_pair_fifo #(
    .PAIR_W (PW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .i_push  (wr_en),
    .i_wdata ({wr_a, wr_b}),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // ---- p0 -> p1: FIFO head into the output register, FSM and beat counter ----
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (vec_len != '0)) begin
            r_state <= RUN;
            r_len   <= vec_len;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (w_xfer && r_last_p1) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_a_p1    <= signed'(w_head[PW-1:BW]);
        r_b_p1    <= signed'(w_head[BW-1:0]);
        r_vld_p1  <= 1'b1;
        r_last_p1 <= (r_cnt == r_len - LEN_W'(1));
        r_cnt     <= r_cnt + LEN_W'(1);
      end else if (w_xfer) begin
        r_vld_p1  <= 1'b0;
        r_last_p1 <= 1'b0;
      end
    end
  end

  assign m.a       = r_a_p1;
  assign m.b       = r_b_p1;
  assign m.valid_o = r_vld_p1;
  assign m.last_o  = r_last_p1;
  assign busy      = (r_state == RUN);
  assign done      = r_done;

`ifdef AXI_MAC_SRC_OVF_EN
  logic r_ovf;

  always_ff @(posedge clock) begin
    if (rst)                r_ovf <= 1'b0;
    else if (wr_en && full) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_axi_mac_src.sv
// Randomized self-checking bench for axi_mac_src against a queue-based reference of the operand stream.
module tb_axi_mac_src;
  import mac_stream_pkg::*;

  localparam int DEPTH = 16;
  localparam int LEN_W = 8;
  localparam int AW    = 14;
  localparam int BW    = 14;

  typedef struct { logic signed [AW-1:0] a; logic signed [BW-1:0] b; } pair_t;
  typedef struct { logic signed [AW-1:0] a; logic signed [BW-1:0] b; logic last; int cyc; } beat_t;

  logic                 clock = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic signed [AW-1:0] wr_a = '0;
  logic signed [BW-1:0] wr_b = '0;
  logic                 full;
  logic [4:0]           level;
  logic                 start = 1'b0;
  logic [LEN_W-1:0]     vec_len = '0;
  logic                 busy;
  logic                 done;
  logic                 ready = 1'b1;
`ifdef AXI_MAC_SRC_OVF_EN
  logic                 ovf;
`endif

  pair_t mq[$];
  beat_t obs[$];
  int    done_cnt = 0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  always #5 clock = ~clock;

  axi_mac_src_if #(.A_W(AW), .B_W(BW)) bus ();
  assign bus.ready_i = ready;

  axi_mac_src #(
    .int_a(6), .frac_a(8), .int_b(6), .frac_b(8), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .full    (full),
    .level   (level),
    .start   (start),
    .vec_len (vec_len),
    .busy    (busy),
    .done    (done),
    .m       (bus)
`ifdef AXI_MAC_SRC_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always @(negedge clock) begin
    cyc++;
    if (!rst && bus.valid_o && ready)
      obs.push_back('{a: bus.a, b: bus.b, last: bus.last_o, cyc: cyc});
    if (!rst && done) done_cnt++;
  end

  task automatic push_pair(input logic signed [AW-1:0] pa, input logic signed [BW-1:0] pb);
    @(posedge clock); #1;
    wr_en = 1'b1; wr_a = pa; wr_b = pb;
    if (mq.size() < DEPTH) mq.push_back('{a: pa, b: pb});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; wr_en = 1'b0; start = 1'b0; end
  endtask

  task automatic start_vec(input int len);
    @(posedge clock); #1;
    wr_en = 1'b0; start = 1'b1; vec_len = LEN_W'(len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (done) ok = 1'b1;
      else if (rnd) begin @(posedge clock); #1; ready = 1'($urandom_range(0, 1)); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.valid_o); else n_pass++;
    n_checks++; if (bus.a !== '0 || bus.b !== '0) $display("FAIL reset_ab: got a=%0d b=%0d want 0 0", bus.a, bus.b); else n_pass++;
    n_checks++; if (bus.last_o !== 1'b0) $display("FAIL reset_last: got %0b want 0", bus.last_o); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %0b %0b want 0 0", busy, done); else n_pass++;
    n_checks++; if (full !== 1'b0 || level !== 5'd0) $display("FAIL reset_fifo: got full=%0b level=%0d want 0 0", full, level); else n_pass++;
`ifdef AXI_MAC_SRC_OVF_EN
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf); else n_pass++;
`endif
    @(posedge clock); #1;
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_basic();
    bit ok; int d0;
    for (int k = 1; k <= 4; k++) push_pair(AW'(k * 256), BW'((k + 1) * 256));
    idle(1);
    @(negedge clock);
    n_checks++; if (int'(level) !== mq.size()) $display("FAIL basic_level: got %0d want %0d", level, mq.size()); else n_pass++;
    obs.delete(); d0 = done_cnt; ready = 1'b1;
    start_vec(4);
    @(negedge clock);
    n_checks++; if (busy !== 1'b1 || bus.valid_o !== 1'b0) $display("FAIL basic_latency1: got busy=%0b valid=%0b want 1 0", busy, bus.valid_o); else n_pass++;
    @(negedge clock);
    n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL basic_latency2: got valid=%0b want 1", bus.valid_o); else n_pass++;
    wait_done(30, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL basic_done_timeout: got no done want done"); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %0b want 0", busy); else n_pass++;
    n_checks++; if (obs.size() !== 4) $display("FAIL basic_count: got %0d want 4", obs.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pair_t e;
      e = mq.pop_front();
      n_checks++;
      if (i >= obs.size() || obs[i].a !== e.a || obs[i].b !== e.b || obs[i].last !== (i == 3) || obs[i].cyc !== obs[0].cyc + i)
        $display("FAIL basic_beat%0d: got a=%0d b=%0d last=%0b cyc=%0d want a=%0d b=%0d last=%0b cyc=%0d",
                 i, obs[i].a, obs[i].b, obs[i].last, obs[i].cyc, e.a, e.b, (i == 3), obs[0].cyc + i);
      else n_pass++;
    end
    @(posedge clock); #1;
    n_checks++; if (done_cnt !== d0 + 1 || done !== 1'b0) $display("FAIL basic_done_pulse: got cnt=%0d done=%0b want %0d 0", done_cnt - d0, done, 1); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok; int d0;
    logic signed [AW-1:0] ha; logic signed [BW-1:0] hb; logic hl;
    for (int k = 1; k <= 4; k++) push_pair(AW'(k * 256), BW'((k + 1) * 256));
    idle(1);
    obs.delete(); d0 = done_cnt; ready = 1'b1;
    start_vec(4);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clock); #1; if (obs.size() == 2) ok = 1'b1; end
    ready = 1'b0;
    ha = bus.a; hb = bus.b; hl = bus.last_o;
    n_checks++; if (!ok || ha !== AW'(3 * 256) || hl !== 1'b0) $display("FAIL stall_beat2: got a=%0d last=%0b want a=%0d last=0", ha, hl, 3 * 256); else n_pass++;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.a !== ha || bus.b !== hb || bus.last_o !== hl)
        $display("FAIL stall_hold: got v=%0b a=%0d b=%0d l=%0b want 1 %0d %0d %0b", bus.valid_o, bus.a, bus.b, bus.last_o, ha, hb, hl);
      else n_pass++;
    end
    @(posedge clock); #1; ready = 1'b1;
    wait_done(30, 1'b0, ok);
    n_checks++; if (!ok || obs.size() !== 4) $display("FAIL stall_count: got %0d beats done=%0b want 4 1", obs.size(), ok); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pair_t e;
      e = mq.pop_front();
      n_checks++;
      if (i >= obs.size() || obs[i].a !== e.a || obs[i].b !== e.b || obs[i].last !== (i == 3))
        $display("FAIL stall_beat%0d: got a=%0d b=%0d last=%0b want a=%0d b=%0d last=%0b", i, obs[i].a, obs[i].b, obs[i].last, e.a, e.b, (i == 3));
      else n_pass++;
    end
    @(posedge clock); #1;
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_bubbles();
    bit ok;
    obs.delete(); ready = 1'b1;
    n_checks++; if (level !== 5'd0) $display("FAIL bubble_empty: got level=%0d want 0", level); else n_pass++;
    start_vec(3);
    for (int k = 0; k < 3; k++) begin
      push_pair(AW'($urandom), BW'($urandom));
      idle(1);
    end
    wait_done(30, 1'b0, ok);
    n_checks++; if (!ok || obs.size() !== 3) $display("FAIL bubble_count: got %0d beats done=%0b want 3 1", obs.size(), ok); else n_pass++;
    n_checks++; if (obs.size() < 2 || obs[1].cyc - obs[0].cyc < 2) $display("FAIL bubble_gap: got gap=%0d want >=2", obs.size() < 2 ? 0 : obs[1].cyc - obs[0].cyc); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      pair_t e;
      e = mq.pop_front();
      n_checks++;
      if (i >= obs.size() || obs[i].a !== e.a || obs[i].b !== e.b || obs[i].last !== (i == 2))
        $display("FAIL bubble_beat%0d: got a=%0d b=%0d last=%0b want a=%0d b=%0d last=%0b", i, obs[i].a, obs[i].b, obs[i].last, e.a, e.b, (i == 2));
      else n_pass++;
    end
  endtask

  task automatic test_full();
    bit ok;
    for (int k = 0; k < DEPTH + 1; k++) push_pair(AW'($urandom), BW'($urandom));
    idle(1);
    @(negedge clock);
    n_checks++; if (full !== 1'b1 || int'(level) !== DEPTH) $display("FAIL full_flag: got full=%0b level=%0d want 1 %0d", full, level, DEPTH); else n_pass++;
`ifdef AXI_MAC_SRC_OVF_EN
    n_checks++; if (ovf !== 1'b1) $display("FAIL full_ovf: got %0b want 1", ovf); else n_pass++;
`endif
    obs.delete(); ready = 1'b1;
    start_vec(8);
    wait_done(40, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL full_done1: got no done want done"); else n_pass++;
    start_vec(8);
    wait_done(40, 1'b0, ok);
    n_checks++; if (!ok || obs.size() !== 16) $display("FAIL full_count: got %0d beats want 16", obs.size()); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      pair_t e;
      e = mq.pop_front();
      n_checks++;
      if (i >= obs.size() || obs[i].a !== e.a || obs[i].b !== e.b || obs[i].last !== (i % 8 == 7))
        $display("FAIL full_beat%0d: got a=%0d b=%0d last=%0b want a=%0d b=%0d last=%0b", i, obs[i].a, obs[i].b, obs[i].last, e.a, e.b, (i % 8 == 7));
      else n_pass++;
    end
    @(negedge clock);
    n_checks++; if (full !== 1'b0 || level !== 5'd0) $display("FAIL full_drained: got full=%0b level=%0d want 0 0", full, level); else n_pass++;
  endtask

  task automatic test_random();
    bit ok; int n; int len;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(2, 12);
      len = $urandom_range(1, n);
      for (int k = 0; k < n; k++) push_pair(AW'($urandom), BW'($urandom));
      idle(1);
      for (int part = 0; part < 2; part++) begin
        int l;
        l = (part == 0) ? len : n - len;
        if (l > 0) begin
          obs.delete();
          start_vec(l);
          wait_done(400, 1'b1, ok);
          ready = 1'b1;
          n_checks++; if (!ok || obs.size() !== l) $display("FAIL rand_count%0d: got %0d beats done=%0b want %0d", it, obs.size(), ok, l); else n_pass++;
          for (int i = 0; i < l; i++) begin
            pair_t e;
            e = mq.pop_front();
            n_checks++;
            if (i >= obs.size() || obs[i].a !== e.a || obs[i].b !== e.b || obs[i].last !== (i == l - 1))
              $display("FAIL rand_beat%0d_%0d: got a=%0d b=%0d last=%0b want a=%0d b=%0d last=%0b", it, i, obs[i].a, obs[i].b, obs[i].last, e.a, e.b, (i == l - 1));
            else n_pass++;
          end
        end
      end
      @(negedge clock);
      n_checks++; if (level !== 5'd0) $display("FAIL rand_level%0d: got %0d want 0", it, level); else n_pass++;
    end
  endtask

  task automatic test_len0_reset();
    bit ok; int d0;
    d0 = done_cnt;
    start_vec(0);
    repeat (3) @(negedge clock);
    n_checks++; if (busy !== 1'b0 || done_cnt !== d0) $display("FAIL len0: got busy=%0b dones=%0d want 0 0", busy, done_cnt - d0); else n_pass++;
    for (int k = 0; k < 4; k++) push_pair(AW'($urandom), BW'($urandom));
    idle(1);
    obs.delete(); ready = 1'b1;
    start_vec(4);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clock); #1; if (obs.size() == 2) ok = 1'b1; end
    n_checks++; if (!ok || obs[0].a !== mq[0].a || obs[1].b !== mq[1].b) $display("FAIL rst_prefix: got a0=%0d b1=%0d want %0d %0d", obs[0].a, obs[1].b, mq[0].a, mq[1].b); else n_pass++;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    mq.delete();
    @(negedge clock);
    n_checks++; if (bus.valid_o !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid: got valid=%0b level=%0d busy=%0b done=%0b want 0 0 0 0", bus.valid_o, level, busy, done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_full();
    test_random();
    test_len0_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
